aes_ct_output_buffer: RTL and testbench

Downstream stage of the AES-128 top level. It captures each 128-bit ciphertext on the CTValid pulse into a small FIFO. Each stored block is serialized as four 32-bit words, most-significant word first, over a valid/ready stream interface to the host/bus side. It also reports occupancy and overflow so the system controller can hold off new Load_Data.

---
 rtl/aes_ct_output_buffer.sv | 99 +++++++++
 tb/tb_aes_ct_output_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_output_buffer.sv
// Ciphertext output FIFO: stores 128-bit blocks, streams each as four 32-bit words MSW first.
// Latency: a block pushed at edge N presents word 0 in the cycle after edge N.
// Backpressure: words hold while out_ready=0; pushes into a full buffer are dropped and flag overflow.
module aes_ct_output_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CTValid,
  input  logic [127:0]      CipherText,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              buf_full,
  output logic              buf_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    word_idx;
  logic [127:0]  head;
  logic          push;
  logic          pop;
  logic          xfer;
  logic          ovf_evt;

  // Status is derived from the count register only, so CTValid never reaches out_valid.
  assign buf_empty = (count == '0);
  assign buf_full  = (count == FULL_CNT);
  assign out_valid = !buf_empty;
  assign out_last  = out_valid && (word_idx == 2'd3);

  assign push    = CTValid && !buf_full;
  assign ovf_evt = CTValid && buf_full;
  assign xfer    = out_valid && out_ready;
  assign pop     = xfer && (word_idx == 2'd3);

  assign head = mem[rd_ptr];

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (word_idx)
        2'd0:    out_data = head[127:96];
        2'd1:    out_data = head[95:64];
        2'd2:    out_data = head[63:32];
        default: out_data = head[31:0];
      endcase
    end
  end

  // Storage needs no reset; stale entries are never visible because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= CipherText;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (xfer) begin
        word_idx <= word_idx + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A fresh overflow wins over a simultaneous clear.
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_ct_output_buffer.sv
// Scoreboard bench for aes_ct_output_buffer: a word-level queue model fed at each edge, checked by a monitor.
module tb_aes_ct_output_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         CTValid = 1'b0;
  logic [127:0] CipherText = '0;
  logic         out_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         buf_full;
  logic         buf_empty;
  logic [CNT_W-1:0] count;
  logic         overflow;

  aes_ct_output_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .CTValid(CTValid), .CipherText(CipherText),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .buf_full(buf_full), .buf_empty(buf_empty),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected word stream: {last, data}; model block count and sticky overflow.
  logic [32:0] exp_q[$];
  int          mdl_cnt = 0;
  bit          mdl_ovf = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge for the upcoming rising edge.
  always @(negedge clk) begin
    bit pop_now;
    bit ovf_evt;
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0;
      mdl_ovf = 1'b0;
      prev_stall = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_count", count, 0);
      chk("rst_buf_empty", buf_empty, 1);
      chk("rst_buf_full", buf_full, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      chk("count", count, mdl_cnt);
      chk("out_valid", out_valid, mdl_cnt != 0);
      chk("buf_full", buf_full, mdl_cnt == DEPTH);
      chk("buf_empty", buf_empty, mdl_cnt == 0);
      chk("overflow", overflow, mdl_ovf);
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      pop_now = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 'x);
        end else begin
          chk("out_data", out_data, exp_q[0][31:0]);
          chk("out_last", out_last, exp_q[0][32]);
          if (out_ready) begin
            pop_now = exp_q[0][32];
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      ovf_evt = 1'b0;
      if (CTValid) begin
        if (mdl_cnt < DEPTH) begin
          for (int w = 0; w < 4; w++) begin
            exp_q.push_back({(w == 3), CipherText[127 - 32*w -: 32]});
          end
          mdl_cnt++;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      if (pop_now) mdl_cnt--;
      if (clr_ovf) mdl_ovf = 1'b0;
      if (ovf_evt) mdl_ovf = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [127:0] d);
    CTValid = 1'b1;
    CipherText = d;
    tick();
    CTValid = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while ((mdl_cnt != 0 || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    vectors++;
    if (mdl_cnt != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words still pending after %0d cycles", exp_q.size(), limit);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d words pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kat;
    logic         bp [7];
    kat = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Known block streamed with continuous ready.
    out_ready = 1'b1;
    pulse(kat);
    chk("kat_latency_valid", out_valid, 1);
    chk("kat_word0", out_data, 32'h3925841d);
    wait_empty(20);
    tick();
    chk("kat_empty_after", buf_empty, 1);

    // Same block under a fixed backpressure pattern.
    out_ready = 1'b0;
    pulse(kat);
    for (int i = 0; i < 7; i++) begin
      out_ready = bp[i];
      tick();
    end
    out_ready = 1'b1;
    wait_empty(20);

    // Fill past capacity with no drain; fifth block must be lost.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse(rnd128());
    tick();
    chk("fill_count", count, 4);
    chk("fill_full", buf_full, 1);
    chk("fill_overflow", overflow, 1);
    out_ready = 1'b1;
    wait_empty(40);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // Push lands on the head block's final handshake: full drops, count==3 accepts.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(rnd128());
    out_ready = 1'b1;
    repeat (3) tick();
    pulse(rnd128());
    chk("simul_full_count", count, 3);
    chk("simul_full_ovf", overflow, 1);
    repeat (3) tick();
    pulse(rnd128());
    chk("simul_three_count", count, 3);
    wait_empty(60);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Ten blocks at drain rate to wrap both pointers several times.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse(rnd128());
      repeat (3) tick();
    end
    wait_empty(40);
    chk("wrap_no_overflow", overflow, 0);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      CTValid    = ($urandom_range(0, 3) == 0);
      CipherText = rnd128();
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_ovf    = ($urandom_range(0, 15) == 0);
      tick();
    end
    CTValid = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    wait_empty(100);

    // Asynchronous reset between edges after two words of a two-block buffer.
    out_ready = 1'b0;
    pulse(rnd128());
    pulse(rnd128());
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_count", count, 0);
    chk("arst_buf_empty", buf_empty, 1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_idle", out_valid, 0);
    out_ready = 1'b1;
    pulse(kat);
    chk("post_rst_word0", out_data, 32'h3925841d);
    wait_empty(20);
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
